// File: rtl/calc_sequencer.sv
// Top-level calculator sequencer: operand/op entry, ALU start/done handshake,
// timeout supervision and result/error display selection.
module calc_sequencer #(
    parameter int DATA_W         = 4,
    parameter int RES_W          = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] sw,
    input  logic              sw4,
    input  logic              BTNU,
    input  logic              BTNL,
    input  logic              alu_done,
    input  logic              alu_error,
    input  logic [RES_W-1:0]  alu_result,
    output logic              alu_start,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_op,
    output logic              alu_signed,
    output logic [RES_W-1:0]  result,
    output logic              confirmed_a,
    output logic              confirmed_b,
    output logic              busy,
    output logic              error,
    output logic [1:0]        err_code,
    output logic [1:0]        display_sel,
    output logic [2:0]        state_code
);

    localparam int              CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [2:0] {
        S_ENTER_A  = 3'd0,
        S_ENTER_B  = 3'd1,
        S_ENTER_OP = 3'd2,
        S_START    = 3'd3,
        S_WAIT     = 3'd4,
        S_SHOW     = 3'd5,
        S_ERROR    = 3'd6
    } state_e;

    state_e            state_q, state_d;
    logic              btnu_q, btnl_q;
    logic              confirm_s, clear_s, wipe_s;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
    logic [2:0]        op_q, op_d;
    logic              sgn_q, sgn_d;
    logic [RES_W-1:0]  res_q, res_d;
    logic              ca_q, ca_d, cb_q, cb_d;
    logic [1:0]        err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              start_q, start_d;
    logic              busy_q, busy_d;
    logic              error_q, error_d;
    logic [1:0]        disp_q, disp_d;

    assign confirm_s = BTNU & ~btnu_q;
    assign clear_s   = BTNL & ~btnl_q;
    // A confirm in SHOW/ERROR returns to operand entry with everything wiped, same as clear.
    assign wipe_s    = clear_s | (confirm_s & ((state_q == S_SHOW) | (state_q == S_ERROR)));

    // Next-state and next-output computation.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        sgn_d   = sgn_q;
        res_d   = res_q;
        ca_d    = ca_q;
        cb_d    = cb_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        if (wipe_s) begin
            state_d = S_ENTER_A;
            a_d     = '0;
            b_d     = '0;
            op_d    = 3'd0;
            sgn_d   = 1'b0;
            res_d   = '0;
            ca_d    = 1'b0;
            cb_d    = 1'b0;
            err_d   = 2'b00;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_ENTER_A: begin
                    if (confirm_s) begin
                        a_d     = sw;
                        ca_d    = 1'b1;
                        state_d = S_ENTER_B;
                    end else begin
                        state_d = S_ENTER_A;
                    end
                end
                S_ENTER_B: begin
                    if (confirm_s) begin
                        b_d     = sw;
                        cb_d    = 1'b1;
                        state_d = S_ENTER_OP;
                    end else begin
                        state_d = S_ENTER_B;
                    end
                end
                S_ENTER_OP: begin
                    if (confirm_s) begin
                        op_d  = sw[2:0];
                        sgn_d = sw4;
                        if (sw[2:0] > 3'd4) begin
                            err_d   = 2'b01;
                            state_d = S_ERROR;
                        end else if (((sw[2:0] == 3'd3) || (sw[2:0] == 3'd4)) && (b_q == '0)) begin
                            // Divide/mod by zero is caught here so the ALU is never launched.
                            err_d   = 2'b10;
                            state_d = S_ERROR;
                        end else begin
                            state_d = S_START;
                        end
                    end else begin
                        state_d = S_ENTER_OP;
                    end
                end
                S_START: begin
                    cnt_d   = CNT_ONE;
                    state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (alu_done) begin
                        cnt_d = '0;
                        if (alu_error) begin
                            err_d   = 2'b10;
                            state_d = S_ERROR;
                        end else begin
                            res_d   = alu_result;
                            state_d = S_SHOW;
                        end
                    end else if (cnt_q == CNT_MAX) begin
                        cnt_d   = '0;
                        err_d   = 2'b11;
                        state_d = S_ERROR;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                S_SHOW, S_ERROR: begin
                    state_d = state_q;
                end
                default: begin
                    state_d = S_ENTER_A;
                    cnt_d   = '0;
                end
            endcase
        end

        start_d = (state_d == S_START);
        busy_d  = (state_d == S_START) || (state_d == S_WAIT);
        error_d = (state_d == S_ERROR);
        case (state_d)
            S_SHOW:  disp_d = 2'b01;
            S_ERROR: disp_d = 2'b10;
            default: disp_d = 2'b00;
        endcase
    end

    // State, datapath and output registers; button history flops reset high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_ENTER_A;
            btnu_q  <= 1'b1;
            btnl_q  <= 1'b1;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= 3'd0;
            sgn_q   <= 1'b0;
            res_q   <= '0;
            ca_q    <= 1'b0;
            cb_q    <= 1'b0;
            err_q   <= 2'b00;
            cnt_q   <= '0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            error_q <= 1'b0;
            disp_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            btnu_q  <= BTNU;
            btnl_q  <= BTNL;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            sgn_q   <= sgn_d;
            res_q   <= res_d;
            ca_q    <= ca_d;
            cb_q    <= cb_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            start_q <= start_d;
            busy_q  <= busy_d;
            error_q <= error_d;
            disp_q  <= disp_d;
        end
    end

    assign alu_start   = start_q;
    assign alu_a       = a_q;
    assign alu_b       = b_q;
    assign alu_op      = op_q;
    assign alu_signed  = sgn_q;
    assign result      = res_q;
    assign confirmed_a = ca_q;
    assign confirmed_b = cb_q;
    assign busy        = busy_q;
    assign error       = error_q;
    assign err_code    = err_q;
    assign display_sel = disp_q;
    assign state_code  = state_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Self-checking bench for calc_sequencer with a behavioural outcome model
// and randomized operand/op/ALU-latency stimulus.
module tb_calc_sequencer;

    localparam int TO = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] sw;
    logic       sw4, BTNU, BTNL, alu_done, alu_error;
    logic [7:0] alu_result;
    logic       alu_start, alu_signed, confirmed_a, confirmed_b, busy, error;
    logic [3:0] alu_a, alu_b;
    logic [2:0] alu_op, state_code;
    logic [7:0] result;
    logic [1:0] err_code, display_sel;

    int total = 0;
    int bad   = 0;
    int start_cnt = 0;
    int b2b = 0;
    logic prev_start = 1'b0;

    calc_sequencer #(.DATA_W(4), .RES_W(8), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .sw(sw), .sw4(sw4), .BTNU(BTNU), .BTNL(BTNL),
        .alu_done(alu_done), .alu_error(alu_error), .alu_result(alu_result),
        .alu_start(alu_start), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_signed(alu_signed), .result(result), .confirmed_a(confirmed_a),
        .confirmed_b(confirmed_b), .busy(busy), .error(error), .err_code(err_code),
        .display_sel(display_sel), .state_code(state_code)
    );

    always #5 clk = ~clk;

    // Count launch pulses and flag any that last longer than one cycle.
    always @(posedge clk) begin
        if (alu_start) begin
            start_cnt <= start_cnt + 1;
            if (prev_start) b2b <= b2b + 1;
        end
        prev_start <= alu_start;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic press_u(input logic [3:0] v, input logic s);
        sw = v; sw4 = s; BTNU = 1'b1;
        tick();
        BTNU = 1'b0;
    endtask

    task automatic press_l();
        BTNL = 1'b1;
        tick();
        BTNL = 1'b0;
    endtask

    task automatic enter_ops(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op, input logic s);
        press_u(a, 1'b0); tick();
        press_u(b, 1'b0); tick();
        press_u(op, s);
    endtask

    // Reference ALU: plain arithmetic on the latched operands.
    function automatic logic [7:0] ref_alu(input int a, input int b, input int op);
        case (op)
            0: return 8'((a + b) & 255);
            1: return 8'((a - b) & 255);
            2: return 8'((a * b) & 255);
            3: return 8'(b == 0 ? 0 : a / b);
            default: return 8'(b == 0 ? 0 : a % b);
        endcase
    endfunction

    task automatic test_reset();
        reset = 1'b1; BTNU = 1'b1; BTNL = 1'b0; sw = 4'd9; sw4 = 1'b0;
        alu_done = 1'b0; alu_error = 1'b0; alu_result = 8'd0;
        #1;
        total++; if (state_code !== 3'd0) begin bad++; $display("FAIL rst_state got=%0d exp=0", state_code); end
        total++; if ({alu_start, busy, error, confirmed_a, confirmed_b, display_sel, err_code, alu_a, result} !== 21'd0) begin
            bad++; $display("FAIL rst_outputs got=%0h exp=0", {alu_start, busy, error, confirmed_a, confirmed_b, display_sel, err_code, alu_a, result}); end
        tick(); reset = 1'b0;
        repeat (3) tick();
        total++; if (state_code !== 3'd0) begin bad++; $display("FAIL held_btn_no_event state got=%0d exp=0", state_code); end
        BTNU = 1'b0; tick();
        press_u(4'd9, 1'b0);
        total++; if (state_code !== 3'd1 || alu_a !== 4'd9 || confirmed_a !== 1'b1) begin
            bad++; $display("FAIL first_press state=%0d a=%0d ca=%0d exp 1/9/1", state_code, alu_a, confirmed_a); end
        tick(); press_l();
        total++; if (state_code !== 3'd0 || alu_a !== 4'd0) begin bad++; $display("FAIL clear_b state=%0d a=%0d exp 0/0", state_code, alu_a); end
    endtask

    task automatic test_add();
        int s0;
        s0 = start_cnt;
        tick(); enter_ops(4'd10, 4'd3, 4'd0, 1'b0);
        total++; if (state_code !== 3'd3 || alu_start !== 1'b1 || busy !== 1'b1) begin
            bad++; $display("FAIL add_start state=%0d start=%0d busy=%0d exp 3/1/1", state_code, alu_start, busy); end
        tick();
        total++; if (state_code !== 3'd4 || alu_start !== 1'b0) begin
            bad++; $display("FAIL add_wait state=%0d start=%0d exp 4/0", state_code, alu_start); end
        repeat (3) tick();
        alu_done = 1'b1; alu_result = ref_alu(10, 3, 0); tick(); alu_done = 1'b0;
        total++; if (state_code !== 3'd5 || result !== 8'd13 || display_sel !== 2'b01 || busy !== 1'b0) begin
            bad++; $display("FAIL add_show state=%0d res=%0d disp=%0d exp 5/13/1", state_code, result, display_sel); end
        total++; if (start_cnt - s0 !== 1) begin bad++; $display("FAIL add_start_count got=%0d exp=1", start_cnt - s0); end
        tick(); press_u(4'd0, 1'b0);
        total++; if ({state_code, alu_a, alu_b, alu_op, result, confirmed_a, confirmed_b} !== 24'd0) begin
            bad++; $display("FAIL add_cleared got=%0h exp=0", {state_code, alu_a, alu_b, alu_op, result, confirmed_a, confirmed_b}); end
    endtask

    task automatic test_errors();
        int s0;
        s0 = start_cnt;
        tick(); enter_ops(4'd7, 4'd0, 4'd3, 1'b0);
        total++; if (state_code !== 3'd6 || err_code !== 2'b10 || error !== 1'b1 || display_sel !== 2'b10) begin
            bad++; $display("FAIL div0 state=%0d err=%0d error=%0d disp=%0d exp 6/2/1/2", state_code, err_code, error, display_sel); end
        repeat (3) tick();
        total++; if (start_cnt - s0 !== 0) begin bad++; $display("FAIL div0_no_start got=%0d exp=0", start_cnt - s0); end
        press_u(4'd0, 1'b0);
        total++; if (state_code !== 3'd0 || err_code !== 2'b00) begin bad++; $display("FAIL err_exit state=%0d err=%0d exp 0/0", state_code, err_code); end
        tick(); enter_ops(4'd5, 4'd2, 4'd6, 1'b1);
        total++; if (state_code !== 3'd6 || err_code !== 2'b01 || alu_op !== 3'd6) begin
            bad++; $display("FAIL bad_op state=%0d err=%0d op=%0d exp 6/1/6", state_code, err_code, alu_op); end
        tick(); press_l();
        total++; if (state_code !== 3'd0 || err_code !== 2'b00 || alu_op !== 3'd0) begin
            bad++; $display("FAIL bad_op_clear state=%0d err=%0d op=%0d exp 0/0/0", state_code, err_code, alu_op); end
    endtask

    task automatic test_timeout();
        tick(); enter_ops(4'd4, 4'd2, 4'd2, 1'b0);
        for (int k = 1; k <= TO; k++) begin
            tick();
            total++; if (state_code !== 3'd4) begin bad++; $display("FAIL to_wait_%0d state=%0d exp=4", k, state_code); end
        end
        tick();
        total++; if (state_code !== 3'd6 || err_code !== 2'b11) begin
            bad++; $display("FAIL timeout state=%0d err=%0d exp 6/3", state_code, err_code); end
        tick(); press_u(4'd0, 1'b0);
        tick(); enter_ops(4'd4, 4'd2, 4'd2, 1'b0);
        repeat (TO) tick();
        alu_done = 1'b1; alu_result = 8'd8; tick(); alu_done = 1'b0;
        total++; if (state_code !== 3'd5 || result !== 8'd8 || err_code !== 2'b00) begin
            bad++; $display("FAIL done_on_last state=%0d res=%0d err=%0d exp 5/8/0", state_code, result, err_code); end
        tick(); press_u(4'd0, 1'b0);
    endtask

    task automatic test_clear_wait();
        tick(); enter_ops(4'd5, 4'd6, 4'd2, 1'b0);
        tick(); tick();
        press_l();
        total++; if (state_code !== 3'd0 || busy !== 1'b0) begin bad++; $display("FAIL clear_wait state=%0d busy=%0d exp 0/0", state_code, busy); end
        tick(); tick();
        alu_done = 1'b1; alu_result = 8'hAA; tick(); alu_done = 1'b0;
        total++; if (state_code !== 3'd0 || result !== 8'd0) begin
            bad++; $display("FAIL late_done state=%0d res=%0d exp 0/0", state_code, result); end
        tick(); press_u(4'd3, 1'b0);
        tick();
        sw = 4'd4; BTNU = 1'b1; BTNL = 1'b1; tick(); BTNU = 1'b0; BTNL = 1'b0;
        total++; if (state_code !== 3'd0 || confirmed_a !== 1'b0 || confirmed_b !== 1'b0 || alu_a !== 4'd0) begin
            bad++; $display("FAIL clear_prio state=%0d ca=%0d cb=%0d a=%0d exp 0/0/0/0", state_code, confirmed_a, confirmed_b, alu_a); end
    endtask

    task automatic test_async_reset();
        tick(); enter_ops(4'd2, 4'd3, 4'd0, 1'b1);
        tick(); tick();
        #2 reset = 1'b1;
        #1;
        total++; if ({state_code, busy, alu_start, alu_a, alu_b, alu_op, alu_signed, confirmed_a, confirmed_b} !== 21'd0) begin
            bad++; $display("FAIL async_reset got=%0h exp=0", {state_code, busy, alu_start, alu_a, alu_b, alu_op, alu_signed, confirmed_a, confirmed_b}); end
        tick(); reset = 1'b0; tick();
        total++; if (state_code !== 3'd0) begin bad++; $display("FAIL post_reset state=%0d exp=0", state_code); end
    endtask

    task automatic test_random();
        int a, b, op, s4, dly, aerr, s0, exp_state, exp_err, exp_starts, exp_res;
        logic [3:0] opsw;
        logic [7:0] rv;
        for (int it = 0; it < 24; it++) begin
            a = $urandom_range(0, 15);
            b = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 15);
            op = $urandom_range(0, 7);
            opsw = 4'(op + 8 * $urandom_range(0, 1));
            s4 = $urandom_range(0, 1);
            dly = $urandom_range(1, TO + 2);
            aerr = ($urandom_range(0, 4) == 0) ? 1 : 0;
            rv = ref_alu(a, b, op);
            exp_res = 0;
            if (op > 4) begin exp_state = 6; exp_err = 1; exp_starts = 0; end
            else if ((op == 3 || op == 4) && b == 0) begin exp_state = 6; exp_err = 2; exp_starts = 0; end
            else if (dly > TO) begin exp_state = 6; exp_err = 3; exp_starts = 1; end
            else if (aerr == 1) begin exp_state = 6; exp_err = 2; exp_starts = 1; end
            else begin exp_state = 5; exp_err = 0; exp_starts = 1; exp_res = rv; end
            s0 = start_cnt;
            tick(); enter_ops(4'(a), 4'(b), opsw, 1'(s4));
            if (exp_starts == 1) begin
                tick();
                for (int k = 1; k <= TO; k++) begin
                    total++; if (alu_a !== 4'(a) || alu_b !== 4'(b) || busy !== 1'b1) begin
                        bad++; $display("FAIL rnd%0d_stable a=%0d b=%0d busy=%0d exp %0d/%0d/1", it, alu_a, alu_b, busy, a, b); end
                    if (k == dly) begin
                        alu_done = 1'b1; alu_error = 1'(aerr); alu_result = rv;
                        tick();
                        alu_done = 1'b0; alu_error = 1'b0;
                        break;
                    end
                    tick();
                end
            end
            tick();
            total++; if (state_code !== 3'(exp_state) || err_code !== 2'(exp_err) || result !== 8'(exp_res)) begin
                bad++; $display("FAIL rnd%0d_outcome state=%0d err=%0d res=%0d exp %0d/%0d/%0d", it, state_code, err_code, result, exp_state, exp_err, exp_res); end
            total++; if (alu_op !== 3'(op) || alu_signed !== 1'(s4) || display_sel !== ((exp_state == 5) ? 2'b01 : 2'b10)) begin
                bad++; $display("FAIL rnd%0d_latch op=%0d sgn=%0d disp=%0d exp %0d/%0d", it, alu_op, alu_signed, display_sel, op, s4); end
            total++; if (start_cnt - s0 !== exp_starts) begin
                bad++; $display("FAIL rnd%0d_starts got=%0d exp=%0d", it, start_cnt - s0, exp_starts); end
            press_u(4'd0, 1'b0);
            total++; if (state_code !== 3'd0 || alu_a !== 4'd0 || result !== 8'd0 || err_code !== 2'b00) begin
                bad++; $display("FAIL rnd%0d_exit state=%0d a=%0d res=%0d err=%0d exp 0", it, state_code, alu_a, result, err_code); end
        end
        total++; if (b2b !== 0) begin bad++; $display("FAIL start_back_to_back got=%0d exp=0", b2b); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_errors();
        test_timeout();
        test_clear_wait();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
